// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite sheet fetcher.
//   fetch_state_t   - fetcher FSM states
//   pix_beat_t      - one output pixel beat {data, x, y, last, opaque}
//   SHEET_W_DEF     - default sheet width in pixels
//   SHEET_DEPTH_DEF - default ROM word count
package sprite_pkg;

  localparam int unsigned SHEET_W_DEF     = 420;
  localparam int unsigned SHEET_DEPTH_DEF = 75600;
  localparam int unsigned PIX_W_DEF       = 24;
  localparam int unsigned DIM_W_DEF       = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] data;
    logic [DIM_W_DEF-1:0] x;
    logic [DIM_W_DEF-1:0] y;
    logic                 last;
    logic                 opaque;
  } pix_beat_t;

  localparam int unsigned PIX_BEAT_W = $bits(pix_beat_t);

endpackage

// File: rtl/pix_skid_fifo.sv
// pix_skid_fifo: 2-entry FIFO holding pixel beats between the ROM return
// path and the pixel stream consumer. Push and pop may occur in the same
// cycle, including when full.
//   clk_i, rst_ni   - clock, synchronous active-low reset
//   push_i, wdata_i - write strobe and beat
//   pop_i           - remove head entry (ignored when empty)
//   rdata_o         - head entry
//   count_o         - occupancy, 0..2
module pix_skid_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q;
  logic [1:0]   cnt_q;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // Writing into a full FIFO is safe only when the head leaves this cycle.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/sprite_fetcher.sv
// sprite_fetcher: read-side initiator for the sprite sheet ROM. Takes a
// rectangle request, validates it, walks it row-major issuing one ROM
// address per cycle under credit control, absorbs the ROM's 1-cycle read
// latency and emits a valid/ready pixel stream with in-sprite coordinates.
//   Clk, Reset_n           - clock, synchronous active-low reset
//   start, src_x/y, width,
//   height                 - request strobe and rectangle (sampled in IDLE)
//   busy, done, err        - status; done/err are one-cycle pulses
//   rom_addr, rom_data     - ROM read port (data valid 1 cycle after addr)
//   pix_valid, pix_ready   - output stream handshake
//   pix_data, pix_x, pix_y,
//   pix_last, pix_opaque   - output beat
// Build option: SPRITE_FETCHER_COLOR_KEY_EN adds parameter KEY_COLOR and
// drives pix_opaque low for key-coloured pixels; otherwise pix_opaque is 1
// for every delivered pixel.
module sprite_fetcher
  import sprite_pkg::*;
#(
  parameter int unsigned SHEET_W     = SHEET_W_DEF,
  parameter int unsigned SHEET_DEPTH = SHEET_DEPTH_DEF,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DIM_W       = DIM_W_DEF,
  parameter int unsigned PIX_W       = PIX_W_DEF
`ifdef SPRITE_FETCHER_COLOR_KEY_EN
  ,
  parameter logic [PIX_W-1:0] KEY_COLOR = 24'hFF00FF
`endif
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  src_x,
  input  logic [DIM_W-1:0]  src_y,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [DIM_W-1:0]  pix_x,
  output logic [DIM_W-1:0]  pix_y,
  output logic              pix_last,
  output logic              pix_opaque
);

  localparam logic [ADDR_W-1:0] SW_A    = ADDR_W'(SHEET_W);
  localparam logic [ADDR_W:0]   SW_X    = (ADDR_W+1)'(SHEET_W);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(SHEET_DEPTH);
  localparam logic [ADDR_W:0]   ONE_X   = (ADDR_W+1)'(1);
  localparam logic [DIM_W:0]    SW_D    = (DIM_W+1)'(SHEET_W);
  localparam logic [DIM_W-1:0]  ONE_D   = DIM_W'(1);

  fetch_state_t state_q, state_d;

  logic [DIM_W-1:0]  sx_q, sy_q, w_q, h_q;
  logic [DIM_W-1:0]  col_q, row_q;
  logic [ADDR_W-1:0] row_base_q, rom_addr_q;
  logic              inflight_q;
  logic [DIM_W-1:0]  tag_x_q, tag_y_q;
  logic              tag_last_q;

  logic [DIM_W:0]    xend_c;
  logic [ADDR_W:0]   last_addr_c;
  logic [ADDR_W-1:0] base_c;
  logic              reject_c;
  logic              issue, row_end, last_issue, pop, credit_ok;
  logic [1:0]        fifo_cnt;
  pix_beat_t         wr_beat, rd_beat;

  // Request validation; the last-address product is one bit wider than the
  // ROM address so an oversize rectangle cannot wrap into a legal address.
  assign xend_c      = {1'b0, sx_q} + {1'b0, w_q};
  assign last_addr_c = ((ADDR_W+1)'(sy_q) + (ADDR_W+1)'(h_q) - ONE_X) * SW_X
                     + (ADDR_W+1)'(sx_q) + (ADDR_W+1)'(w_q) - ONE_X;
  assign base_c      = ADDR_W'(sy_q) * SW_A + ADDR_W'(sx_q);
  assign reject_c    = (w_q == '0) || (h_q == '0) || (xend_c > SW_D) ||
                       (last_addr_c >= DEPTH_X);

  // Credit: FIFO slots already used plus the read in flight, minus the beat
  // leaving this cycle, must leave room for the read issued now.
  assign pop        = pix_valid & pix_ready;
  assign credit_ok  = ({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign issue      = (state_q == FETCH) && credit_ok;
  assign row_end    = (col_q == w_q - ONE_D);
  assign last_issue = row_end && (row_q == h_q - ONE_D);

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = CHECK;
      CHECK: begin
        if (reject_c) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: if (issue && last_issue) state_d = DRAIN;
      // Leave as soon as the final beat is accepted so done trails it by one.
      DRAIN: if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)))
               state_d = FIN;
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      sx_q       <= '0;
      sy_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      rom_addr_q <= '0;
      inflight_q <= 1'b0;
      tag_x_q    <= '0;
      tag_y_q    <= '0;
      tag_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if ((state_q == IDLE) && start) begin
        sx_q <= src_x;
        sy_q <= src_y;
        w_q  <= width;
        h_q  <= height;
      end
      // rom_addr_q always holds the address for the next issue, so the first
      // read goes out in the first FETCH cycle.
      if ((state_q == CHECK) && !reject_c) begin
        row_base_q <= base_c;
        rom_addr_q <= base_c;
        col_q      <= '0;
        row_q      <= '0;
      end
      if (issue) begin
        tag_x_q    <= col_q;
        tag_y_q    <= row_q;
        tag_last_q <= last_issue;
        if (row_end) begin
          col_q      <= '0;
          row_q      <= row_q + ONE_D;
          row_base_q <= row_base_q + SW_A;
          if (!last_issue) rom_addr_q <= row_base_q + SW_A;
        end else begin
          col_q      <= col_q + ONE_D;
          rom_addr_q <= rom_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    wr_beat.data = rom_data;
    wr_beat.x    = tag_x_q;
    wr_beat.y    = tag_y_q;
    wr_beat.last = tag_last_q;
`ifdef SPRITE_FETCHER_COLOR_KEY_EN
    wr_beat.opaque = (rom_data != KEY_COLOR);
`else
    wr_beat.opaque = 1'b1;
`endif
  end

  pix_skid_fifo #(.W(PIX_BEAT_W)) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (inflight_q),
    .wdata_i (wr_beat),
    .pop_i   (pop),
    .rdata_o (rd_beat),
    .count_o (fifo_cnt)
  );

  assign rom_addr   = rom_addr_q;
  assign pix_valid  = (fifo_cnt != 2'd0);
  assign pix_data   = rd_beat.data;
  assign pix_x      = rd_beat.x;
  assign pix_y      = rd_beat.y;
  assign pix_last   = rd_beat.last;
  assign pix_opaque = rd_beat.opaque;

endmodule

// File: tb/tb_sprite_fetcher.sv
// tb_sprite_fetcher: self-checking bench for sprite_fetcher. A registered
// ROM model returns a hash of the address; expected pixel streams are built
// from the rectangle by nested loops over (x, y).
module tb_sprite_fetcher;

  typedef struct {
    logic [23:0] d;
    int          x;
    int          y;
    logic        last;
    logic        op;
    int          k;
  } beat_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic [9:0]  src_x = '0, src_y = '0, width = '0, height = '0;
  logic        busy, done, err, pix_valid, pix_last, pix_opaque;
  logic [18:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic [23:0] pix_data;
  logic [9:0]  pix_x, pix_y;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  logic [18:0] addr_tr [0:2047];
  logic        busy_tr [0:2047];
  int done_k, err_k, n_done, n_err, last_hs_k, first_v_k, stall_viol, end_k;
  bit timed_out;

  sprite_fetcher dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .src_x(src_x), .src_y(src_y), .width(width), .height(height),
    .busy(busy), .done(done), .err(err),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .pix_opaque(pix_opaque)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_fn(input logic [18:0] a);
    logic [31:0] h;
    if (a == 19'd0) return 24'hFF00FF;
    if (a == 19'd1) return 24'h123456;
    h = {13'd0, a} * 32'h9E3779B1;
    return h[31:8] ^ {5'd0, a};
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  function automatic void build_exp(input int sx, input int sy, input int w, input int h);
    beat_t       b;
    logic [18:0] a;
    exp_q.delete();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        a      = 19'((sy + y) * 420 + sx + x);
        b.d    = rom_fn(a);
        b.x    = x;
        b.y    = y;
        b.last = (x == w - 1) && (y == h - 1);
        b.k    = 0;
`ifdef SPRITE_FETCHER_COLOR_KEY_EN
        b.op   = (b.d != 24'hFF00FF);
`else
        b.op   = 1'b1;
`endif
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic bit model_reject(input int sx, input int sy, input int w, input int h);
    return (w == 0) || (h == 0) || (sx + w > 420) || ((sy + h - 1) * 420 + sx + w - 1 >= 75600);
  endfunction

  // Issues one request and records a per-cycle trace; k=0 is the first
  // cycle after the start strobe.
  task automatic run_req(input int sx, input int sy, input int w, input int h,
                         input bit rnd, input bit poke);
    int    k;
    bit    pstall;
    beat_t pb, cb;
    obs_q.delete();
    done_k = -1; err_k = -1; n_done = 0; n_err = 0; last_hs_k = -1;
    first_v_k = -1; stall_viol = 0; end_k = -1; timed_out = 0;
    pstall = 0;
    pb = '{24'd0, 0, 0, 1'b0, 1'b0, 0};
    @(negedge Clk);
    start = 1'b1; src_x = 10'(sx); src_y = 10'(sy); width = 10'(w); height = 10'(h);
    @(negedge Clk);
    start = 1'b0;
    k = 0;
    forever begin
      pix_ready = (end_k < 0 && rnd) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (poke && end_k < 0 && busy && !done && !err && ($urandom_range(0, 2) == 0)) begin
        start  = 1'b1;
        src_x  = 10'($urandom_range(0, 400));
        src_y  = 10'($urandom_range(0, 100));
        width  = 10'($urandom_range(1, 5));
        height = 10'($urandom_range(1, 5));
      end
      addr_tr[k] = rom_addr;
      busy_tr[k] = busy;
      cb = '{pix_data, int'(pix_x), int'(pix_y), pix_last, pix_opaque, k};
      if (pix_valid && first_v_k < 0) first_v_k = k;
      if (pstall && (!pix_valid || cb.d !== pb.d || cb.x != pb.x || cb.y != pb.y ||
                     cb.last !== pb.last || cb.op !== pb.op))
        stall_viol++;
      if (pix_valid && pix_ready) begin
        obs_q.push_back(cb);
        last_hs_k = k;
      end
      pstall = pix_valid && !pix_ready;
      pb = cb;
      if (done) begin n_done++; if (done_k < 0) done_k = k; end
      if (err)  begin n_err++;  if (err_k < 0)  err_k = k;  end
      if (end_k < 0 && (done || err)) end_k = k;
      if (end_k >= 0 && k >= end_k + 2) break;
      if (k == 2000) begin timed_out = 1; break; end
      k++;
      @(negedge Clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_tests++;
    if ({busy, done, err, pix_valid, pix_last, pix_opaque} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy/done/err/valid/last/opaque=%b expected 000000",
               {busy, done, err, pix_valid, pix_last, pix_opaque});
    end
    n_tests++;
    if (rom_addr !== 19'd0 || pix_data !== 24'd0 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%0d data=%h x=%0d y=%0d expected all 0",
               rom_addr, pix_data, pix_x, pix_y);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [18:0] ea [4];
    ea[0] = 19'd0; ea[1] = 19'd1; ea[2] = 19'd420; ea[3] = 19'd421;
    run_req(0, 0, 2, 2, 1'b0, 1'b0);
    build_exp(0, 0, 2, 2);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (addr_tr[i+1] !== ea[i]) begin
        n_fail++;
        $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, addr_tr[i+1], ea[i]);
      end
    end
    n_tests++;
    if (first_v_k != 3) begin
      n_fail++;
      $display("FAIL basic_first_valid: got cycle %0d expected 3", first_v_k);
    end
    n_tests++;
    if (obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 4", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
          obs_q[i].last !== exp_q[i].last || obs_q[i].op !== exp_q[i].op || obs_q[i].k != 3 + i) begin
        n_fail++;
        $display("FAIL basic_beat[%0d]: got d=%h x=%0d y=%0d last=%b op=%b cyc=%0d expected d=%h x=%0d y=%0d last=%b op=%b cyc=%0d",
                 i, obs_q[i].d, obs_q[i].x, obs_q[i].y, obs_q[i].last, obs_q[i].op, obs_q[i].k,
                 exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].op, 3 + i);
      end
    end
    n_tests++;
    if (n_done != 1 || done_k != last_hs_k + 1) begin
      n_fail++;
      $display("FAIL basic_done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
               n_done, done_k, last_hs_k + 1);
    end
    n_tests++;
    if (done_k < 0 || busy_tr[0] !== 1'b1 || busy_tr[done_k] !== 1'b1 || busy_tr[done_k+1] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got busy at check/done/after=%b%b%b expected 110",
               busy_tr[0], (done_k < 0) ? 1'bx : busy_tr[done_k], (done_k < 0) ? 1'bx : busy_tr[done_k+1]);
    end
    // Right-hand edge of the sheet.
    run_req(418, 5, 2, 1, 1'b0, 1'b0);
    n_tests++;
    if (addr_tr[1] !== 19'd2518 || addr_tr[2] !== 19'd2519) begin
      n_fail++;
      $display("FAIL edge_addr: got %0d,%0d expected 2518,2519", addr_tr[1], addr_tr[2]);
    end
    n_tests++;
    if (obs_q.size() != 2 || n_done != 1) begin
      n_fail++;
      $display("FAIL edge_count: got %0d beats %0d done expected 2 beats 1 done", obs_q.size(), n_done);
    end
  endtask

  task automatic test_reject();
    int   t_sx [7] = '{419,   0,   0, 0,   1, 0,   0};
    int   t_sy [7] = '{  0, 179, 179, 0,   0, 0, 178};
    int   t_w  [7] = '{  2, 420, 420, 0, 420, 3,   5};
    int   t_h  [7] = '{  1,   1,   2, 1,   1, 0,   2};
    bit   t_rj [7] = '{  1,   0,   1, 1,   1, 1,   0};
    logic [18:0] pa;
    int   moved;
    for (int t = 0; t < 7; t++) begin
      pa = rom_addr;
      run_req(t_sx[t], t_sy[t], t_w[t], t_h[t], 1'b0, 1'b0);
      n_tests++;
      if (timed_out) begin n_fail++; $display("FAIL reject_timeout[%0d]: no done/err", t); end
      if (t_rj[t]) begin
        moved = 0;
        for (int k = 0; k <= end_k + 2; k++) if (addr_tr[k] !== pa) moved++;
        n_tests++;
        if (n_err != 1 || err_k != 0 || n_done != 0 || obs_q.size() != 0 || moved != 0 || busy_tr[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL reject[%0d]: got err=%0d@%0d done=%0d beats=%0d addr_moves=%0d busy1=%b expected err=1@0 done=0 beats=0 moves=0 busy1=0",
                   t, n_err, err_k, n_done, obs_q.size(), moved, busy_tr[1]);
        end
      end else begin
        build_exp(t_sx[t], t_sy[t], t_w[t], t_h[t]);
        n_tests++;
        if (n_err != 0 || n_done != 1 || obs_q.size() != exp_q.size()) begin
          n_fail++;
          $display("FAIL accept[%0d]: got err=%0d done=%0d beats=%0d expected 0,1,%0d",
                   t, n_err, n_done, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
          n_tests++;
          if (obs_q[i].d !== exp_q[i].d || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
              obs_q[i].last !== exp_q[i].last) begin
            n_fail++;
            $display("FAIL accept[%0d]_beat[%0d]: got d=%h x=%0d y=%0d last=%b expected d=%h x=%0d y=%0d last=%b",
                     t, i, obs_q[i].d, obs_q[i].x, obs_q[i].y, obs_q[i].last,
                     exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].last);
          end
        end
      end
    end
  endtask

  task automatic test_random_stall();
    int sx, sy, w, h;
    bit rj;
    for (int r = 0; r < 10; r++) begin
      if (r == 0) begin
        sx = 7; sy = 11; w = 3; h = 3;
      end else begin
        sx = $urandom_range(0, 425); sy = $urandom_range(0, 185);
        w  = $urandom_range(0, 6);   h  = $urandom_range(0, 5);
      end
      rj = model_reject(sx, sy, w, h);
      run_req(sx, sy, w, h, 1'b1, 1'b0);
      build_exp(sx, sy, w, h);
      if (rj) exp_q.delete();
      n_tests++;
      if (timed_out || n_err != int'(rj) || n_done != int'(!rj) || stall_viol != 0) begin
        n_fail++;
        $display("FAIL rand[%0d] (%0d,%0d %0dx%0d): got timeout=%b err=%0d done=%0d stall_changes=%0d expected 0,%0d,%0d,0",
                 r, sx, sy, w, h, timed_out, n_err, n_done, stall_viol, rj, !rj);
      end
      n_tests++;
      if (obs_q.size() != exp_q.size() || (!rj && done_k != last_hs_k + 1)) begin
        n_fail++;
        $display("FAIL rand[%0d]_count: got %0d beats done@%0d expected %0d beats done@%0d",
                 r, obs_q.size(), done_k, exp_q.size(), last_hs_k + 1);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_tests++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
            obs_q[i].last !== exp_q[i].last || obs_q[i].op !== exp_q[i].op) begin
          n_fail++;
          $display("FAIL rand[%0d]_beat[%0d]: got d=%h x=%0d y=%0d last=%b op=%b expected d=%h x=%0d y=%0d last=%b op=%b",
                   r, i, obs_q[i].d, obs_q[i].x, obs_q[i].y, obs_q[i].last, obs_q[i].op,
                   exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].op);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int late;
    @(negedge Clk);
    start = 1'b1; src_x = 10'd3; src_y = 10'd4; width = 10'd10; height = 10'd10; pix_ready = 1'b0;
    @(negedge Clk);
    start = 1'b0;
    repeat (6) @(negedge Clk);
    n_tests++;
    if (busy !== 1'b1 || pix_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreq_state: got busy=%b valid=%b expected 1,1", busy, pix_valid);
    end
    Reset_n = 1'b0;
    @(negedge Clk);
    n_tests++;
    if ({busy, done, err, pix_valid, pix_last, pix_opaque} !== 6'b0 || rom_addr !== 19'd0 ||
        pix_data !== 24'd0 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
      n_fail++;
      $display("FAIL midreq_reset: got ctrl=%b addr=%0d data=%h x=%0d y=%0d expected all 0",
               {busy, done, err, pix_valid, pix_last, pix_opaque}, rom_addr, pix_data, pix_x, pix_y);
    end
    Reset_n = 1'b1;
    pix_ready = 1'b1;
    late = 0;
    repeat (3) begin
      @(negedge Clk);
      if (pix_valid || done || busy) late++;
    end
    n_tests++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL midreq_abandon: got %0d cycles with valid/done/busy expected 0", late);
    end
    run_req(2, 3, 1, 1, 1'b0, 1'b0);
    build_exp(2, 3, 1, 1);
    n_tests++;
    if (timed_out || n_done != 1 || obs_q.size() != 1 ||
        (obs_q.size() == 1 && (obs_q[0].d !== exp_q[0].d || obs_q[0].last !== 1'b1))) begin
      n_fail++;
      $display("FAIL after_reset_1x1: got done=%0d beats=%0d d=%h expected done=1 beats=1 d=%h",
               n_done, obs_q.size(), (obs_q.size() > 0) ? obs_q[0].d : 24'hx, exp_q[0].d);
    end
  endtask

  task automatic test_busy_start();
    int idle_bad;
    run_req(5, 7, 4, 3, 1'b1, 1'b1);
    build_exp(5, 7, 4, 3);
    n_tests++;
    if (timed_out || n_done != 1 || n_err != 0 || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL busy_start: got timeout=%b done=%0d err=%0d beats=%0d expected 0,1,0,%0d",
               timed_out, n_done, n_err, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y ||
          obs_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL busy_start_beat[%0d]: got d=%h x=%0d y=%0d last=%b expected d=%h x=%0d y=%0d last=%b",
                 i, obs_q[i].d, obs_q[i].x, obs_q[i].y, obs_q[i].last,
                 exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].last);
      end
    end
    idle_bad = 0;
    repeat (3) begin
      @(negedge Clk);
      if (busy || pix_valid) idle_bad++;
    end
    n_tests++;
    if (idle_bad != 0) begin
      n_fail++;
      $display("FAIL busy_start_idle: got %0d busy cycles after done expected 0", idle_bad);
    end
  endtask

  task automatic test_color_key();
    logic op0, op1;
`ifdef SPRITE_FETCHER_COLOR_KEY_EN
    op0 = 1'b0; op1 = 1'b1;
`else
    op0 = 1'b1; op1 = 1'b1;
`endif
    run_req(0, 0, 2, 1, 1'b1, 1'b0);
    n_tests++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL key_count: got %0d expected 2", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0].d !== 24'hFF00FF || obs_q[1].d !== 24'h123456 ||
          obs_q[0].op !== op0 || obs_q[1].op !== op1) begin
        n_fail++;
        $display("FAIL key_opaque: got %h/%b %h/%b expected ff00ff/%b 123456/%b",
                 obs_q[0].d, obs_q[0].op, obs_q[1].d, obs_q[1].op, op0, op1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_random_stall();
    test_reset_mid();
    test_busy_start();
    test_color_key();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
